area_hs_param: RTL



---
 rtl/area_hs_param.sv | 139 +++++++++++++
 1 files changed

// File: rtl/area_hs_param.sv
// Handshaked W x W -> 2W unsigned multiplier (shift-and-add, one bit per cycle).
// Define AREA_ZERO_SKIP_EN to finish early once the remaining multiplier bits are all zero.
module area_hs_param #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic [W-1:0]   data_in_1,
  input  logic           dav_in_1_,
  input  logic [W-1:0]   data_in_2,
  input  logic           dav_in_2_,
  output logic           rfd_in_1,
  output logic           rfd_in_2,
  output logic [2*W-1:0] data_out,
  output logic           dav_out_,
  input  logic           rfd_out,
  output logic [2:0]     dbg_state
);

  // Handshake: both producers hold dav_ low with data until rfd_in drops (load),
  // then raise dav_ before the result is offered; the consumer raises rfd_out to
  // accept, sees dav_out_ low, and drops rfd_out to retire the transaction.

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IN   = 3'd0,
    S_MUL  = 3'd1,
    S_REL  = 3'd2,
    S_WRDY = 3'd3,
    S_DAV  = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_a, w_a_nxt;
  logic [W-1:0]   r_b, w_b_nxt;
  logic [2*W-1:0] r_pr, w_pr_nxt;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_rfd, w_rfd_nxt;
  logic           r_dav_n, w_dav_n_nxt;

  // Low half of the shifted-in addend is zero, so only the upper half needs an adder.
  logic [W:0]     w_upper_sum;
  logic [2*W-1:0] w_pr_step;

  always_comb begin
    w_upper_sum = {1'b0, r_pr[2*W-1:W]} + (r_b[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    w_pr_step   = {w_upper_sum, r_pr[W-1:1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_pr_nxt    = r_pr;
    w_count_nxt = r_count;
    w_rfd_nxt   = r_rfd;
    w_dav_n_nxt = r_dav_n;
    case (r_state)
      S_IN: begin
        if (!dav_in_1_ && !dav_in_2_) begin
          w_a_nxt     = data_in_1;
          w_b_nxt     = data_in_2;
          w_pr_nxt    = '0;
          w_count_nxt = CW'(W);
          w_rfd_nxt   = 1'b0;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
`ifdef AREA_ZERO_SKIP_EN
        if (r_b == '0) begin
          w_pr_nxt    = r_pr >> r_count;
          w_count_nxt = '0;
          w_state_nxt = S_REL;
        end else
`endif
        begin
          w_pr_nxt    = w_pr_step;
          w_b_nxt     = r_b >> 1;
          w_count_nxt = r_count - CW'(1);
          if (r_count == CW'(1)) begin
            w_state_nxt = S_REL;
          end
        end
      end
      S_REL: begin
        if (dav_in_1_ && dav_in_2_) begin
          w_state_nxt = S_WRDY;
        end
      end
      S_WRDY: begin
        if (rfd_out) begin
          w_dav_n_nxt = 1'b0;
          w_state_nxt = S_DAV;
        end
      end
      S_DAV: begin
        if (!rfd_out) begin
          w_dav_n_nxt = 1'b1;
          w_rfd_nxt   = 1'b1;
          w_state_nxt = S_IN;
        end
      end
      default: begin
        w_state_nxt = S_IN;
        w_rfd_nxt   = 1'b1;
        w_dav_n_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_state <= S_IN;
      r_a     <= '0;
      r_b     <= '0;
      r_pr    <= '0;
      r_count <= '0;
      r_rfd   <= 1'b1;
      r_dav_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_pr    <= w_pr_nxt;
      r_count <= w_count_nxt;
      r_rfd   <= w_rfd_nxt;
      r_dav_n <= w_dav_n_nxt;
    end
  end

  assign rfd_in_1  = r_rfd;
  assign rfd_in_2  = r_rfd;
  assign data_out  = r_pr;
  assign dav_out_  = r_dav_n;
  assign dbg_state = r_state;

endmodule
